// File: rtl/shift_out.sv
// Parallel-to-serial transmitter: captures a WIDTH-bit word on a rising edge of sp and
// sends it MSB-first on p_out, one bit per clock, raising fp when the last bit is out.
module shift_out #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] p_parallel,
    input  logic             sp,
    output logic             p_out,
    output logic             p_valid,
    output logic             fp,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sp_prev_q;
    logic             p_out_q, p_out_d;
    logic             p_valid_q, p_valid_d;
    logic             fp_q, fp_d;
    logic             start;

    // sp_prev_q resets to 0, so sp already high at reset release counts as a start
    assign start = sp & ~sp_prev_q;

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        p_out_d   = p_out_q;
        p_valid_d = p_valid_q;
        fp_d      = fp_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StShift;
                    sreg_d    = p_parallel << 1;
                    p_out_d   = p_parallel[WIDTH-1];
                    p_valid_d = 1'b1;
                    fp_d      = 1'b0;
                    cnt_d     = CntW'(1);
                end
            end
            StShift: begin
                // Starts seen here are dropped, not queued
                if (cnt_q == CntMax) begin
                    state_d   = StDone;
                    p_out_d   = 1'b0;
                    p_valid_d = 1'b0;
                    fp_d      = 1'b1;
                    cnt_d     = '0;
                end else begin
                    p_out_d = sreg_q[WIDTH-1];
                    sreg_d  = sreg_q << 1;
                    cnt_d   = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            sreg_q    <= '0;
            cnt_q     <= '0;
            sp_prev_q <= 1'b0;
            p_out_q   <= 1'b0;
            p_valid_q <= 1'b0;
            fp_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            sp_prev_q <= sp;
            p_out_q   <= p_out_d;
            p_valid_q <= p_valid_d;
            fp_q      <= fp_d;
        end
    end

    assign p_out   = p_out_q;
    assign p_valid = p_valid_q;
    assign fp      = fp_q;
    assign busy    = (state_q == StShift);

endmodule
